// File: rtl/inference_result_collector_pkg.sv
// Shared definitions for the inference result collector, the network core
// and the label ROM: collector state encoding and default data widths.
package inference_result_collector_pkg;

    // Collector sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        CMP    = 3'd3,
        FIN    = 3'd4
    } state_t;

    // Default widths shared with the network core and the label ROM
    localparam int unsigned LABEL_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 10;

endpackage

// File: rtl/inference_result_collector_label_rom.sv
// Label ROM: synchronous read, one cycle of latency from addr to data.
// Contents are supplied by the INIT parameter (entry i at bits
// [i*LABEL_W +: LABEL_W]) so the system top fixes the label set.
// Ports:
//   clk   in   clock, rising edge
//   addr  in   ADDR_W   read address
//   data  out  LABEL_W  registered label for the previous cycle's addr
module label_rom
    import inference_result_collector_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned LABEL_W = LABEL_W_DEF,
    parameter logic [(2**ADDR_W)*LABEL_W-1:0] INIT = '0
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [LABEL_W-1:0] data
);

    // Registered read of the addressed entry
    always_ff @(posedge clk) begin
        data <= INIT[LABEL_W*32'(addr) +: LABEL_W];
    end

endmodule

// File: rtl/inference_result_collector.sv
// Inference result collector: launches one network inference per sample,
// captures the result on net_done, compares it against the label ROM and
// accumulates total / correct / timed-out counts for the run.
// The label ROM lives outside this block; only its address/data ports are here.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   run_start      in   one-cycle request to begin a run
//   net_start      out  one-cycle launch pulse to the network core
//   net_result     in   LABEL_W  network classification, valid with net_done
//   net_done       in   one-cycle completion pulse from the network core
//   label_addr     out  ADDR_W   label ROM address
//   label_data     in   LABEL_W  label ROM data, one cycle after label_addr
//   total_count    out  CNT_W    samples completed this run
//   correct_count  out  CNT_W    samples whose result matched the label
//   timeout_count  out  CNT_W    samples abandoned on timeout
//   busy           out  high from LAUNCH through CMP
//   run_done       out  sticky high after the last sample, cleared on run_start
module inference_result_collector
    import inference_result_collector_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 750,
    parameter int unsigned LABEL_W     = LABEL_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_start,
    output logic               net_start,
    input  logic [LABEL_W-1:0] net_result,
    input  logic               net_done,
    output logic [ADDR_W-1:0]  label_addr,
    input  logic [LABEL_W-1:0] label_data,
    output logic [CNT_W-1:0]   total_count,
    output logic [CNT_W-1:0]   correct_count,
    output logic [CNT_W-1:0]   timeout_count,
    output logic               busy,
    output logic               run_done
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_SAMPLES - 1);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [LABEL_W-1:0]  result_q;
    logic                timed_out;

    // idx only changes on the CMP->LAUNCH edge, so the ROM address is
    // stable from LAUNCH through CMP and label_data is valid in CMP.
    assign label_addr = idx;

    // Sequencer, counters and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            result_q      <= '0;
            timed_out     <= 1'b0;
            net_start     <= 1'b0;
            total_count   <= '0;
            correct_count <= '0;
            timeout_count <= '0;
            busy          <= 1'b0;
            run_done      <= 1'b0;
        end else begin
            net_start <= 1'b0;
            unique case (state)
                IDLE, FIN: begin
                    if (run_start) begin
                        idx           <= '0;
                        total_count   <= '0;
                        correct_count <= '0;
                        timeout_count <= '0;
                        run_done      <= 1'b0;
                        busy          <= 1'b1;
                        net_start     <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A result on the final wait cycle still counts as a result
                    if (net_done) begin
                        result_q  <= net_result;
                        timed_out <= 1'b0;
                        state     <= CMP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_count <= timeout_count + CNT_W'(1);
                        timed_out     <= 1'b1;
                        state         <= CMP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                CMP: begin
                    total_count <= total_count + CNT_W'(1);
                    if (!timed_out && (result_q == label_data)) begin
                        correct_count <= correct_count + CNT_W'(1);
                    end
                    if (idx == IDX_LAST) begin
                        busy     <= 1'b0;
                        run_done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        idx       <= idx + ADDR_W'(1);
                        net_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_result_collector.sv
// Self-checking bench for inference_result_collector with a 4-sample run,
// a 16-cycle timeout, a bench-side label ROM and a scripted network model.
module tb_inference_result_collector;

    localparam int NS = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run_start = 1'b0;
    logic       net_start;
    logic [7:0] net_result = '0;
    logic       net_done = 1'b0;
    logic [9:0] label_addr;
    logic [7:0] label_data = '0;
    logic [9:0] total_count, correct_count, timeout_count;
    logic       busy, run_done;

    inference_result_collector #(
        .NUM_SAMPLES(NS), .LABEL_W(8), .ADDR_W(10), .CNT_W(10), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .run_start(run_start), .net_start(net_start),
        .net_result(net_result), .net_done(net_done), .label_addr(label_addr),
        .label_data(label_data), .total_count(total_count),
        .correct_count(correct_count), .timeout_count(timeout_count),
        .busy(busy), .run_done(run_done)
    );

    always #5 clk = ~clk;

    // Scenario: labels, per-sample response delay (<=0 = never) and value
    logic [7:0] labels  [NS];
    int         rsp_delay [NS];
    logic [7:0] rsp_val [NS];
    bit         spurious = 0;   // extra net_done during every LAUNCH cycle
    bit         poke = 0;       // free-running net_done pulses
    int         launch_no = 0;

    int checks = 0;
    int failures = 0;

    // Synchronous label ROM model, one cycle latency
    always @(posedge clk) begin
        label_data <= (label_addr < 10'(NS)) ? labels[label_addr[1:0]] : 8'h00;
    end

    // Network core model: answers rsp_delay cycles after the net_start cycle
    initial begin
        bit pending;
        int cnt;
        int cur;
        pending = 0; cnt = 0; cur = 0;
        forever begin
            @(negedge clk);
            net_done = poke;
            if (!rst) begin
                pending = 0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        net_done   = 1'b1;
                        net_result = rsp_val[cur];
                        pending    = 0;
                    end
                end
                if (net_start === 1'b1) begin
                    cur = launch_no % NS;
                    launch_no++;
                    pending = 0;
                    if (rsp_delay[cur] > 0) begin
                        pending = 1;
                        cnt = rsp_delay[cur];
                    end
                    if (spurious) begin
                        net_done   = 1'b1;
                        net_result = ~labels[cur];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: each sample either answers within the timeout window or is
    // abandoned after TO wait cycles; a sample costs launch + wait + compare.
    task automatic model_run(output int e_tot, output int e_cor, output int e_to, output int e_cyc);
        int cyc;
        e_tot = NS; e_cor = 0; e_to = 0; cyc = 0;
        for (int s = 0; s < NS; s++) begin
            if (rsp_delay[s] >= 1 && rsp_delay[s] <= TO) begin
                if (rsp_val[s] == labels[s]) e_cor++;
                cyc += 2 + rsp_delay[s];
            end else begin
                e_to++;
                cyc += 2 + TO;
            end
        end
        e_cyc = cyc + 1;
    endtask

    // Runs one full collection; inject>0 pulses run_start on that cycle
    task automatic run_and_check(input string tag, input int inject);
        int e_tot, e_cor, e_to, e_cyc, cycles;
        model_run(e_tot, e_cor, e_to, e_cyc);
        launch_no = 0;
        @(negedge clk); run_start = 1'b1;
        @(negedge clk); run_start = 1'b0; cycles = 1;
        check({tag, "_launch_busy"}, busy, 1);
        check({tag, "_launch_start"}, net_start, 1);
        while (run_done !== 1'b1 && cycles < 2000) begin
            run_start = (cycles == inject);
            @(negedge clk);
            cycles++;
        end
        run_start = 1'b0;
        check({tag, "_cycles"}, cycles, e_cyc);
        check({tag, "_total"}, total_count, e_tot);
        check({tag, "_correct"}, correct_count, e_cor);
        check({tag, "_timeout"}, timeout_count, e_to);
        check({tag, "_busy_end"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_sticky"}, run_done, 1);
        check({tag, "_no_launch"}, net_start, 0);
    endtask

    task automatic randomize_scenario();
        for (int s = 0; s < NS; s++) begin
            labels[s] = 8'($urandom_range(0, 255));
            rsp_delay[s] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 20));
            rsp_val[s] = ($urandom_range(0, 1) == 1) ? labels[s] : 8'($urandom_range(0, 255));
        end
        spurious = bit'($urandom_range(0, 1));
    endtask

    initial begin
        int cyc;
        labels    = '{8'd3, 8'd7, 8'd0, 8'd9};
        rsp_delay = '{5, 5, 5, 5};
        rsp_val   = '{8'd3, 8'd7, 8'd0, 8'd9};

        // Reset held for two cycles, then idle with stray net_done pulses
        repeat (2) @(negedge clk);
        #1;
        check("rst_total", total_count, 0);
        check("rst_correct", correct_count, 0);
        check("rst_timeout", timeout_count, 0);
        check("rst_flags", {net_start, busy, run_done}, 0);
        check("rst_addr", label_addr, 0);
        rst = 1'b1;
        poke = 1;
        repeat (4) @(negedge clk);
        poke = 0;
        @(negedge clk);
        check("idle_flags", {net_start, busy, run_done}, 0);
        check("idle_total", total_count, 0);

        // All correct
        run_and_check("all_ok", 0);

        // Mixed results
        rsp_val = '{8'd3, 8'd1, 8'd0, 8'd2};
        run_and_check("mixed", 0);

        // Sample 2 never answers
        rsp_val   = '{8'd3, 8'd7, 8'd0, 8'd9};
        rsp_delay = '{5, 5, -1, 5};
        run_and_check("timeout", 0);

        // Protocol edges: stray done in LAUNCH, run_start in WAIT,
        // answer on the final wait cycle
        rsp_delay = '{5, TO, 3, 5};
        spurious  = 1;
        run_and_check("edges", 4);
        spurious  = 0;

        // Randomized scenarios
        for (int r = 0; r < 5; r++) begin
            randomize_scenario();
            run_and_check($sformatf("rand%0d", r), 0);
        end

        // Reset during WAIT of sample 2, then a clean restart
        spurious  = 0;
        rsp_delay = '{5, 5, 5, 5};
        launch_no = 0;
        @(negedge clk); run_start = 1'b1;
        @(negedge clk); run_start = 1'b0;
        cyc = 0;
        while (launch_no < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_s2", launch_no, 3);
        repeat (2) @(negedge clk);
        check("mid_pre_total", total_count, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_counts", {total_count, correct_count, timeout_count}, 0);
        check("mid_rst_flags", {net_start, busy, run_done}, 0);
        check("mid_rst_addr", label_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        randomize_scenario();
        run_and_check("after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
